user_rom_pipe: RTL and testbench
================================

// Module: user_rom_pipe
// PURPOSE
//   Parametrised read-only OBI subordinate for the user domain. Serves a word table of NumWords x 32 bit
//   with a configurable fixed read latency and one accepted request per cycle. Writes and out-of-range
//   reads return an error response. Sits behind the user-domain OBI demux, next to other user peripherals.
// PARAMETERS
//   ObiCfg    obi_pkg::ObiDefaultConfig   OBI bus config (AddrWidth, DataWidth=32, IdWidth)
//   obi_req_t logic                       OBI request struct type
//   obi_rsp_t logic                       OBI response struct type
//   NumWords  8                           table depth in 32-bit words, 1..256, need not be a power of 2
//   Latency   2                           cycles from grant to rvalid, legal range 1..4
//   Contents  user_rom_pkg::DefaultTable  logic [NumWords-1:0][31:0], word i served at byte offset 4*i
// PORTS
//   clk_i        in   1      clock
//   rst_ni       in   1      asynchronous reset, active low
//   obi_req_i    in   struct OBI request (req, a.addr, a.we, a.be, a.aid)
//   obi_rsp_o    out  struct OBI response (gnt, rvalid, r.rdata, r.rid, r.err, r.r_optional)
//   cnt_clr_i    in   1      synchronous clear of both access counters
//   rd_cnt_o     out  16     number of successful reads, saturating
//   err_cnt_o    out  16     number of error responses, saturating
// BEHAVIOUR
//   - Reset: rvalid=0, rdata=0, rid=0, err=0, counters=0. All pipeline stage valids are cleared.
//     In-flight requests are dropped and never answered. The master resets with the SoC.
//   - gnt = obi_req_i.req, combinational. Handshake: req&gnt in cycle T gives exactly one response,
//     rvalid=1, in cycle T+Latency. Back-to-back requests give back-to-back responses in order.
//   - Pipeline: Latency stages of {valid, id, err, rdata}. Stage 0 computes the result from the
//     accepted request; the later stages only shift. rvalid/rdata/rid/err come from the last stage.
//   - Decode: idx = addr[2+IdxW-1:2] with IdxW = max(1,$clog2(NumWords)). Upper address bits are
//     ignored because the demux already selected the region. addr[1:0] and be are ignored, and the
//     full word is always returned.
//   - Result: we=1 gives err=1, rdata=0. we=0 with idx>=NumWords gives err=1, rdata=0.
//     Otherwise err=0 and rdata=Contents[idx]. When rvalid=0, rdata/err/rid hold 0.
//   - r_optional is always 0. The block has no backpressure and rready is not used.
//   - Counters update in the cycle rvalid=1: +1 to rd_cnt if err=0, else +1 to err_cnt.
//     Both saturate at 16'hFFFF.
//   - cnt_clr_i=1 in the same cycle as an increment: the clear wins, and the counter reads 0 next cycle.
// CONFIGURATION
//   - Macro USER_ROM_ACCESS_CNT_EN.
//   - Defined: the counters are implemented as described above.
//   - Undefined: no counter flops, rd_cnt_o=err_cnt_o=16'h0, cnt_clr_i is ignored.
//   - The port list is identical in both builds.
// STRUCTURE
//   - user_rom_pkg holds: rom_word_t (logic [31:0]), CntWidth=16, DefaultTable (NumWords=8 string
//     table, zero-padded), and function rom_idx_w(NumWords) returning IdxW.
//   - Sub-module user_rom_pipe_stage: one register stage of {valid,id,err,rdata} with async reset.
//     Instantiated Latency times through a generate loop.
// TESTING
//   1. Latency=2: req at T with addr=0x0, aid=3 -> T+2: rvalid=1, rid=3, err=0, rdata=Contents[0].
//      rvalid is 0 at T+1 and at T+3.
//   2. Latency=3: reads of idx 0..7 in 8 consecutive cycles -> 8 consecutive rvalid cycles starting
//      at T+3, data in order, no gaps.
//   3. Write: we=1 to addr=0x4 -> err=1, rdata=0 after Latency. Read of 0x4 afterwards returns the
//      unchanged Contents[1].
//   4. NumWords=6: read addr=0x18 (idx 6) -> err=1, rdata=0. Read addr=0x14 -> err=0, Contents[5].
//   5. rst_ni low for 1 cycle at T+1 after a request at T -> no rvalid at T+Latency, and the next
//      request is answered normally.
//   6. Macro defined: 3 reads + 1 write -> rd_cnt=3, err_cnt=1. cnt_clr_i asserted during a final
//      read response -> both counters 0. Macro undefined -> both counters stay 0 throughout.

Source files
------------

// File: rtl/user_rom_pkg.sv
// Shared types and constants for the user-domain read-only OBI table (user_rom_pipe).
// Holds the default OBI bus config and request/response structs used when the
// integrator does not override them, the ROM word type, counter width, the
// default table contents and the index-width helper.
package user_rom_pkg;

  typedef logic [31:0] rom_word_t;

  localparam int unsigned CntWidth = 16;

  // Minimal OBI bus description: only the widths this block depends on.
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } rom_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    rom_obi_a_chan_t a;
  } rom_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
  } rom_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    rom_obi_r_chan_t r;
  } rom_obi_rsp_t;

  // ASCII "user_rom_pipe v1", zero-padded to 8 words; element 0 is the rightmost entry.
  localparam rom_word_t [7:0] DefaultTable = {
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h6520_7631, 32'h5f70_6970, 32'h5f72_6f6d, 32'h7573_6572
  };

  // Index width; a single-word table still gets a 1-bit index.
  function automatic int unsigned rom_idx_w(int unsigned num_words);
    return (num_words <= 2) ? 1 : $clog2(num_words);
  endfunction

endpackage

// File: rtl/user_rom_pipe_stage.sv
// One register stage of the user_rom_pipe response pipeline.
// Ports: clk_i/rst_ni (async active-low reset clears everything),
//        valid_i/id_i/err_i/rdata_i stage input, valid_o/id_o/err_o/rdata_o stage output.
module user_rom_pipe_stage
  import user_rom_pkg::*;
#(
  parameter int unsigned IdW = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           valid_i,
  input  logic [IdW-1:0] id_i,
  input  logic           err_i,
  input  rom_word_t      rdata_i,
  output logic           valid_o,
  output logic [IdW-1:0] id_o,
  output logic           err_o,
  output rom_word_t      rdata_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      id_o    <= '0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      valid_o <= valid_i;
      id_o    <= id_i;
      err_o   <= err_i;
      rdata_o <= rdata_i;
    end
  end

endmodule

// File: rtl/user_rom_pipe.sv
// Read-only OBI subordinate serving a NumWords x 32-bit table with a fixed
// Latency (1..4) from grant to rvalid, one request accepted per cycle.
// Writes and out-of-range reads get an error response with zero data.
// Ports: clk_i, rst_ni (async, active low), obi_req_i / obi_rsp_o (OBI),
//        cnt_clr_i (sync clear of counters), rd_cnt_o / err_cnt_o (saturating).
// Build option: define USER_ROM_ACCESS_CNT_EN to implement the access counters;
// otherwise both counter outputs are tied to zero and cnt_clr_i is ignored.
module user_rom_pipe
  import user_rom_pkg::*;
#(
  parameter obi_cfg_t                    ObiCfg    = ObiDefaultConfig,
  parameter type                         obi_req_t = rom_obi_req_t,
  parameter type                         obi_rsp_t = rom_obi_rsp_t,
  parameter int unsigned                 NumWords  = 8,
  parameter int unsigned                 Latency   = 2,
  parameter logic [NumWords-1:0][31:0]   Contents  = DefaultTable
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  obi_req_t            obi_req_i,
  output obi_rsp_t            obi_rsp_o,
  input  logic                cnt_clr_i,
  output logic [CntWidth-1:0] rd_cnt_o,
  output logic [CntWidth-1:0] err_cnt_o
);

  localparam int unsigned IdW  = ObiCfg.IdWidth;
  localparam int unsigned IdxW = rom_idx_w(NumWords);

  // Upper address bits are already decoded by the demux; byte lanes are ignored.
  logic [IdxW-1:0] idx;
  logic            in_range;
  assign idx      = obi_req_i.a.addr[2 +: IdxW];
  assign in_range = (32'(idx) < NumWords);

  // Stage 0 input: the result is computed here, later stages only shift.
  logic           st0_vld;
  logic [IdW-1:0] st0_id;
  logic           st0_err;
  rom_word_t      st0_data;

  always_comb begin
    st0_vld  = obi_req_i.req;
    st0_id   = '0;
    st0_err  = 1'b0;
    st0_data = '0;
    if (obi_req_i.req) begin
      st0_id = obi_req_i.a.aid;
      if (obi_req_i.a.we || !in_range) begin
        st0_err = 1'b1;
      end else begin
        st0_data = Contents[idx];
      end
    end
  end

  logic           s_vld  [Latency];
  logic [IdW-1:0] s_id   [Latency];
  logic           s_err  [Latency];
  rom_word_t      s_data [Latency];

  for (genvar i = 0; i < Latency; i++) begin : g_stage
    if (i == 0) begin : g_first
      user_rom_pipe_stage #(.IdW(IdW)) u_stage (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (st0_vld),
        .id_i    (st0_id),
        .err_i   (st0_err),
        .rdata_i (st0_data),
        .valid_o (s_vld[i]),
        .id_o    (s_id[i]),
        .err_o   (s_err[i]),
        .rdata_o (s_data[i])
      );
    end else begin : g_next
      user_rom_pipe_stage #(.IdW(IdW)) u_stage (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (s_vld[i-1]),
        .id_i    (s_id[i-1]),
        .err_i   (s_err[i-1]),
        .rdata_i (s_data[i-1]),
        .valid_o (s_vld[i]),
        .id_o    (s_id[i]),
        .err_o   (s_err[i]),
        .rdata_o (s_data[i])
      );
    end
  end

  logic rsp_vld;
  logic rsp_err;
  assign rsp_vld = s_vld[Latency-1];
  assign rsp_err = s_err[Latency-1];

  // No backpressure: every request is granted in the cycle it is presented.
  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = obi_req_i.req;
    obi_rsp_o.rvalid       = rsp_vld;
    obi_rsp_o.r.rdata      = s_data[Latency-1];
    obi_rsp_o.r.rid        = s_id[Latency-1];
    obi_rsp_o.r.err        = rsp_err;
    obi_rsp_o.r.r_optional = 1'b0;
  end

`ifdef USER_ROM_ACCESS_CNT_EN
  logic [CntWidth-1:0] rd_cnt_q, rd_cnt_d;
  logic [CntWidth-1:0] err_cnt_q, err_cnt_d;

  // Clear has priority over a same-cycle increment.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    if (cnt_clr_i) begin
      rd_cnt_d  = '0;
      err_cnt_d = '0;
    end else if (rsp_vld) begin
      if (!rsp_err && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
      if (rsp_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_cnt_o  = rd_cnt_q;
  assign err_cnt_o = err_cnt_q;
`else
  assign rd_cnt_o  = '0;
  assign err_cnt_o = '0;
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
`endif

  logic unused_req;
  assign unused_req = ^obi_req_i;

endmodule

// File: tb/tb_user_rom_pipe.sv
module tb_user_rom_pipe;
  import user_rom_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [5:0][31:0] TblB = {
    32'h6666_0005, 32'h5555_0004, 32'h4444_0003,
    32'h3333_0002, 32'h2222_0001, 32'h1111_0000
  };

  rom_obi_req_t req_a, req_b;
  rom_obi_rsp_t rsp_a, rsp_b;
  logic         clr_a, clr_b;
  logic [15:0]  rd_a, err_a, rd_b, err_b;

  user_rom_pipe #(.Latency(2)) dut_a (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .obi_req_i (req_a),
    .obi_rsp_o (rsp_a),
    .cnt_clr_i (clr_a),
    .rd_cnt_o  (rd_a),
    .err_cnt_o (err_a)
  );

  user_rom_pipe #(.NumWords(6), .Latency(3), .Contents(TblB)) dut_b (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .obi_req_i (req_b),
    .obi_rsp_o (rsp_b),
    .cnt_clr_i (clr_b),
    .rd_cnt_o  (rd_b),
    .err_cnt_o (err_b)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  id;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: pop the scoreboard whenever a response is presented.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_a.rvalid) begin
      if (q_a.size() == 0) cmp("a_unexpected_rvalid", 32'(rsp_a.rvalid), 32'd0);
      else begin
        e = q_a.pop_front();
        cmp("a_rsp_cycle", cyc, e.cyc);
        cmp("a_rid", 32'(rsp_a.r.rid), 32'(e.id));
        cmp("a_err", 32'(rsp_a.r.err), 32'(e.err));
        cmp("a_rdata", rsp_a.r.rdata, e.data);
        cmp("a_r_optional", 32'(rsp_a.r.r_optional), 32'd0);
      end
    end else begin
      cmp("a_idle_zero", 32'(|{rsp_a.r.rdata, rsp_a.r.rid, rsp_a.r.err, rsp_a.r.r_optional}),
          32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rsp_b.rvalid) begin
      if (q_b.size() == 0) cmp("b_unexpected_rvalid", 32'(rsp_b.rvalid), 32'd0);
      else begin
        e = q_b.pop_front();
        cmp("b_rsp_cycle", cyc, e.cyc);
        cmp("b_rid", 32'(rsp_b.r.rid), 32'(e.id));
        cmp("b_err", 32'(rsp_b.r.err), 32'(e.err));
        cmp("b_rdata", rsp_b.r.rdata, e.data);
      end
    end else begin
      cmp("b_idle_zero", 32'(|{rsp_b.r.rdata, rsp_b.r.rid, rsp_b.r.err, rsp_b.r.r_optional}),
          32'd0);
    end
  end

  // Present one request for one cycle; optionally record the expected response.
  task automatic issue(input bit sel_b, input logic [31:0] addr, input logic we,
                       input logic [3:0] aid, input bit push, input logic exp_err,
                       input logic [31:0] exp_data);
    exp_t e;
    rom_obi_req_t r;
    @(negedge clk);
    r         = '0;
    r.req     = 1'b1;
    r.a.addr  = addr;
    r.a.we    = we;
    r.a.be    = 4'h3;
    r.a.wdata = 32'hdead_beef;
    r.a.aid   = aid;
    e.id      = aid;
    e.err     = exp_err;
    e.data    = exp_data;
    if (sel_b) begin
      req_a = '0;
      req_b = r;
      e.cyc = cyc + 3;
      if (push) q_b.push_back(e);
      #1 cmp("b_gnt", 32'(rsp_b.gnt), 32'd1);
    end else begin
      req_b = '0;
      req_a = r;
      e.cyc = cyc + 2;
      if (push) q_a.push_back(e);
      #1 cmp("a_gnt", 32'(rsp_a.gnt), 32'd1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_a = '0;
      req_b = '0;
      #1 cmp("gnt_idle", 32'(rsp_a.gnt | rsp_b.gnt), 32'd0);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] rd_exp,
                           input logic [15:0] err_exp);
`ifdef USER_ROM_ACCESS_CNT_EN
    cmp({name, "_rd_cnt"}, 32'(rd_a), 32'(rd_exp));
    cmp({name, "_err_cnt"}, 32'(err_a), 32'(err_exp));
`else
    cmp({name, "_rd_cnt"}, 32'(rd_a), 32'd0);
    cmp({name, "_err_cnt"}, 32'(err_a), 32'd0);
`endif
  endtask

  initial begin
    req_a = '0;
    req_b = '0;
    clr_a = 1'b0;
    clr_b = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    cmp("rst_a_rvalid", 32'(rsp_a.rvalid), 32'd0);
    cmp("rst_b_rvalid", 32'(rsp_b.rvalid), 32'd0);
    cmp("rst_a_rsp_fields", 32'(|{rsp_a.r.rdata, rsp_a.r.rid, rsp_a.r.err}), 32'd0);
    cmp("rst_counters", 32'(|{rd_a, err_a, rd_b, err_b}), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Single read, Latency 2, idle neighbours checked by the monitor
    issue(0, 32'h0, 1'b0, 4'd3, 1, 1'b0, 32'h7573_6572);
    idle(4);

    // Write is rejected and leaves contents untouched; ignored address bits
    issue(0, 32'h4, 1'b1, 4'd1, 1, 1'b1, 32'h0);
    issue(0, 32'h4, 1'b0, 4'd2, 1, 1'b0, 32'h5f72_6f6d);
    issue(0, 32'hffff_0008, 1'b0, 4'd7, 1, 1'b0, 32'h5f70_6970);
    issue(0, 32'h7, 1'b0, 4'd15, 1, 1'b0, 32'h5f72_6f6d);
    issue(0, 32'h1c, 1'b0, 4'd4, 1, 1'b0, 32'h0);
    idle(4);

    // Latency 3, NumWords 6: eight back-to-back reads, idx 6 and 7 out of range
    issue(1, 32'h00, 1'b0, 4'd0, 1, 1'b0, 32'h1111_0000);
    issue(1, 32'h04, 1'b0, 4'd1, 1, 1'b0, 32'h2222_0001);
    issue(1, 32'h08, 1'b0, 4'd2, 1, 1'b0, 32'h3333_0002);
    issue(1, 32'h0c, 1'b0, 4'd3, 1, 1'b0, 32'h4444_0003);
    issue(1, 32'h10, 1'b0, 4'd4, 1, 1'b0, 32'h5555_0004);
    issue(1, 32'h14, 1'b0, 4'd5, 1, 1'b0, 32'h6666_0005);
    issue(1, 32'h18, 1'b0, 4'd6, 1, 1'b1, 32'h0);
    issue(1, 32'h1c, 1'b0, 4'd7, 1, 1'b1, 32'h0);
    idle(5);

    // Reset one cycle after a request: that request is never answered
    issue(0, 32'h0, 1'b0, 4'd5, 0, 1'b0, 32'h0);
    @(negedge clk);
    req_a = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check_cnt("after_reset", 16'd0, 16'd0);
    issue(0, 32'hc, 1'b0, 4'd6, 1, 1'b0, 32'h6520_7631);
    idle(4);
    check_cnt("post_reset_read", 16'd1, 16'd0);

    // Counters: clear alone, then 3 reads + 1 write
    @(negedge clk);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check_cnt("clear_idle", 16'd0, 16'd0);
    issue(0, 32'h0, 1'b0, 4'd1, 1, 1'b0, 32'h7573_6572);
    issue(0, 32'h8, 1'b1, 4'd2, 1, 1'b1, 32'h0);
    issue(0, 32'h4, 1'b0, 4'd3, 1, 1'b0, 32'h5f72_6f6d);
    issue(0, 32'hc, 1'b0, 4'd4, 1, 1'b0, 32'h6520_7631);
    idle(4);
    check_cnt("three_reads_one_write", 16'd3, 16'd1);

    // Clear coincides with the final read response: clear wins
    issue(0, 32'h0, 1'b0, 4'd9, 1, 1'b0, 32'h7573_6572);
    @(negedge clk);
    req_a = '0;
    @(negedge clk);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check_cnt("clear_vs_incr", 16'd0, 16'd0);
    cmp("b_counters_unused", 32'(|{rd_b, err_b}), 32'd0);
    idle(6);

    cmp("a_queue_drained", 32'(q_a.size()), 32'd0);
    cmp("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
